// File: rtl/piano_pkg.sv
// Shared definitions for the piano voice path.
// Holds note-ID constants, per-voice field widths and the allocator FSM encoding.
package piano_pkg;

  localparam int unsigned NOTE_W = 4;
  localparam int unsigned OCT_W  = 3;

  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS   = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS   = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd12;

  typedef enum logic [1:0] {StIdle, StScan, StCommit} alloc_state_e;

  // 0 (all-notes-off) and 1..12 are legal; 13..15 are dropped at accept.
  function automatic logic note_legal(logic [NOTE_W-1:0] note);
    return note <= NOTE_B;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Key-event handshake from the keyboard decode path into the voice allocator.
//   ev_valid/ev_ready : valid/ready handshake
//   ev_press          : 1 = press, 0 = release
//   ev_note           : note ID (0 = all-notes-off)
//   ev_octave         : octave latched with a press
interface voice_allocator_if
  import piano_pkg::*;
  ();
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_press;
  logic [NOTE_W-1:0] ev_note;
  logic [OCT_W-1:0]  ev_octave;

  modport master (output ev_valid, ev_press, ev_note, ev_octave, input ev_ready);
  modport slave  (input ev_valid, ev_press, ev_note, ev_octave, output ev_ready);
endinterface

// File: rtl/voice_slot.sv
// One tone-generator voice: active flag, note, octave, saturating age, start pulse.
//   load_i    : (re)trigger with note_i/octave_i, age cleared, start pulsed
//   release_i : drop active, clear age (note/octave hold)
//   clear_i   : all-notes-off, same effect as release
//   age_inc_i : bump age if active, saturating
module voice_slot
  import piano_pkg::*;
#(
  parameter int unsigned AGE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              release_i,
  input  logic              clear_i,
  input  logic              age_inc_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [OCT_W-1:0]  octave_i,
  output logic              active_o,
  output logic [NOTE_W-1:0] note_o,
  output logic [OCT_W-1:0]  octave_o,
  output logic [AGE_W-1:0]  age_o,
  output logic              start_o
);
  localparam logic [AGE_W-1:0] AgeOne = 1;
  localparam logic [AGE_W-1:0] AgeMax = '1;

  logic              active_q, active_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [OCT_W-1:0]  octave_q, octave_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic              start_q, start_d;

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    octave_d = octave_q;
    age_d    = age_q;
    start_d  = 1'b0;
    if (clear_i || release_i) begin
      active_d = 1'b0;
      age_d    = '0;
    end else if (load_i) begin
      active_d = 1'b1;
      note_d   = note_i;
      octave_d = octave_i;
      age_d    = '0;
      start_d  = 1'b1;
    end else if (age_inc_i && active_q && (age_q != AgeMax)) begin
      age_d = age_q + AgeOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      note_q   <= '0;
      octave_q <= '0;
      age_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      octave_q <= octave_d;
      age_q    <= age_d;
      start_q  <= start_d;
    end
  end

  assign active_o = active_q;
  assign note_o   = note_q;
  assign octave_o = octave_q;
  assign age_o    = age_q;
  assign start_o  = start_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: free-first, oldest-steal.
// Accepts one key event at a time on ev, scans the voice pool one voice per cycle,
// then commits a single update. Outputs (all registered):
//   voice_active/voice_start : per-voice sounding flag and (re)trigger pulse
//   voice_note/voice_octave  : packed per-voice note and octave, voice i at the low end
//   steal_count              : saturating count of voices stolen
module voice_allocator
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned AGE_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  voice_allocator_if.slave             ev,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [OCT_W*NUM_VOICES-1:0]  voice_octave,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic [7:0]                   steal_count
);
  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_VOICES - 1);
  localparam logic [IdxW-1:0] IdxOne  = 1;

  logic [NUM_VOICES-1:0] slot_active, slot_start;
  logic [NOTE_W-1:0]     slot_note   [NUM_VOICES];
  logic [OCT_W-1:0]      slot_octave [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age    [NUM_VOICES];
  logic [NUM_VOICES-1:0] load_v, release_v, age_inc_v;
  logic                  clear_all;

  alloc_state_e      state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, tgt;
  logic              press_q, press_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [OCT_W-1:0]  oct_q, oct_d;
  logic              match_found_q, match_found_d, free_found_q, free_found_d;
  logic              old_found_q, old_found_d;
  logic [IdxW-1:0]   match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;
  logic [7:0]        steal_q, steal_d;
  logic              ready_q, ready_d;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_v[i]),
      .release_i (release_v[i]),
      .clear_i   (clear_all),
      .age_inc_i (age_inc_v[i]),
      .note_i    (note_q),
      .octave_i  (oct_q),
      .active_o  (slot_active[i]),
      .note_o    (slot_note[i]),
      .octave_o  (slot_octave[i]),
      .age_o     (slot_age[i]),
      .start_o   (slot_start[i])
    );
    assign voice_note[i*NOTE_W +: NOTE_W]  = slot_note[i];
    assign voice_octave[i*OCT_W +: OCT_W]  = slot_octave[i];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    press_d       = press_q;
    note_d        = note_q;
    oct_d         = oct_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    steal_d       = steal_q;
    load_v        = '0;
    release_v     = '0;
    age_inc_v     = '0;
    clear_all     = 1'b0;
    tgt           = '0;
    unique case (state_q)
      StIdle: begin
        // Illegal notes are consumed here without leaving IDLE.
        if (ev.ev_valid && note_legal(ev.ev_note)) begin
          press_d       = ev.ev_press;
          note_d        = ev.ev_note;
          oct_d         = ev.ev_octave;
          idx_d         = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
          state_d       = StScan;
        end
      end
      StScan: begin
        // Scanning in ascending index order: first hit wins for match/free,
        // strict greater-than keeps the lowest index on age ties.
        if (slot_active[idx_q] && (slot_note[idx_q] == note_q) && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = idx_q;
        end
        if (!slot_active[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (slot_active[idx_q] && (!old_found_q || (slot_age[idx_q] > old_age_q))) begin
          old_found_d = 1'b1;
          old_idx_d   = idx_q;
          old_age_d   = slot_age[idx_q];
        end
        if (idx_q == IdxLast) state_d = StCommit;
        else                  idx_d   = idx_q + IdxOne;
      end
      StCommit: begin
        state_d = StIdle;
        if (note_q == NOTE_NONE) begin
          clear_all = 1'b1;
        end else if (press_q) begin
          if (match_found_q)     tgt = match_idx_q;
          else if (free_found_q) tgt = free_idx_q;
          else begin
            tgt = old_idx_q;
            if (steal_q != 8'hFF) steal_d = steal_q + 8'd1;
          end
          load_v[tgt] = 1'b1;
          age_inc_v   = slot_active & ~load_v;
        end else if (match_found_q) begin
          release_v[match_idx_q] = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      press_q       <= 1'b0;
      note_q        <= '0;
      oct_q         <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= '0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      press_q       <= press_d;
      note_q        <= note_d;
      oct_q         <= oct_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
      ready_q       <= ready_d;
    end
  end

  assign ev.ev_ready    = ready_q;
  assign voice_active   = slot_active;
  assign voice_start    = slot_start;
  assign steal_count    = steal_q;

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice scheduler between the PS/2 keyboard decode path and the tone-generation datapath. Takes one-at-a-time key press/release events (note IDs 1–12 within the current octave) and assigns them to a fixed pool of tone-generator voices. Uses a free-first, oldest-steal policy. Drives per-voice note, octave, active and start outputs that the octave synthesiser consumes in place of a raw 12-bit key bitmap.

## Interface
- `NUM_VOICES`, default 4: number of tone-generator voices; legal range 2–8.
- `AGE_W`, default 4: width of each per-voice age counter; saturating.

Ports:
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `ev_valid` in 1: key event present.
- `ev_ready` out 1: allocator can accept an event.
- `ev_press` in 1: 1 = press, 0 = release.
- `ev_note` in 4: note ID, 1=C … 12=B, 0 = all-notes-off, 13–15 illegal.
- `ev_octave` in 3: octave latched with a press.
- `voice_active` out NUM_VOICES: voice currently sounding.
- `voice_note` out 4*NUM_VOICES: note ID per voice, voice i in bits [4i+3:4i].
- `voice_octave` out 3*NUM_VOICES: octave per voice.
- `voice_start` out NUM_VOICES: one-cycle pulse when a voice is (re)triggered.
- `steal_count` out 8: saturating count of voice steals.

## Operation
- FSM states: IDLE, SCAN, COMMIT.
- **IDLE**
  - `ev_ready`=1.
  - On `ev_valid`&&`ev_ready`, latch press/note/octave, set idx=0, go to SCAN.
  - Illegal notes 13–15 are accepted and discarded; the FSM stays in IDLE.
- **SCAN**
  - Evaluates voice idx, one voice per cycle, and records three candidates:
    - match: lowest-index active voice with equal note;
    - free: lowest-index inactive voice;
    - oldest: active voice with maximum age, ties to lowest index.
  - At idx=NUM_VOICES-1, go to COMMIT.
- **COMMIT** (one cycle, then IDLE)
  - Press with match: retrigger the match voice. Pulse its start, set its age=0, update its octave.
  - Press, no match, free exists: load note and octave into the free voice, set active=1, age=0, pulse start.
  - Press, no match, no free voice: overwrite the oldest voice the same way, and increment `steal_count` (saturates at 255).
  - Every press: each other active voice increments its age, saturating at 2^AGE_W-1.
  - Release with match: clear that voice's active bit. Note and octave hold their last values.
  - Release, no match: no change.
  - `ev_note`=0 (either polarity): clear all active bits and all ages. No start pulses.
- Inactive voices carry age 0.

## Timing
- Reset values:
  - `ev_ready`=1 after reset releases.
  - `voice_active`, `voice_note`, `voice_octave`, `voice_start` and `steal_count` are all 0.
  - All ages are 0; state is IDLE.
- Accept at edge E0. SCAN occupies edges E1..E_N. Outputs update at edge E_{N+1}; `voice_start` is high for exactly the cycle following E_{N+1}.
- Latency from accept to output update is NUM_VOICES+1 cycles. Earliest next accept is at edge E_{N+2}, so sustained throughput is one event per NUM_VOICES+2 cycles.
- `ev_ready` is low throughout SCAN and COMMIT. `ev_valid` and payload must be held by the source until accepted. The payload is sampled only at accept.
- Inputs that change during SCAN/COMMIT are ignored.
- All outputs are registered. There is no combinational path from `ev_*` to any output.
- Reset asserted mid-SCAN/COMMIT immediately returns all state to reset values and discards the event; no start pulse occurs.

## Structure
- The shared package `piano_pkg` holds:
  - note-ID constants (NOTE_NONE=0, NOTE_C=1 … NOTE_B=12);
  - the FSM state encoding;
  - the per-voice record widths (NOTE_W=4, OCT_W=3).
- One sub-module, `voice_slot`, holds one voice's registers (active, note, octave, age, start) with load / retrigger / release / clear / age-increment controls. The allocator instantiates NUM_VOICES of them and owns the FSM and scan comparators.

## Test plan
All scenarios use NUM_VOICES=4.
- **Reset/idle:** assert reset mid-SCAN → all outputs 0, `ev_ready`=1 the cycle after deassert; `voice_start` never pulses.
- **Fill order:** press C, E, G, B (octave 4) back-to-back with `ev_valid` held → voices 0..3 get notes 1, 5, 8, 12. Each `voice_start` pulses 6 cycles after its accept; `ev_ready` low for 5 cycles per event.
- **Steal:** after the fill, press D → voice 0 (oldest, age 3) becomes note 3, `steal_count`=1. Press F → voice 1 becomes note 6, `steal_count`=2.
- **Retrigger/release:** press E twice → one voice only, start pulsed twice, `voice_octave` updated on the second press. Release E → that voice inactive. Release A (not held) → no change.
- **All-off/illegal:** event with note 0 → `voice_active`=0000. Note 14 → accepted, `ev_ready` stays 1, no state change.
- **Saturation:** 300 steals → `steal_count`=255. Ages stay ≤15 over 20 presses on one retriggered voice while others are held.
